mux_sel_reg: RTL and testbench

MUX_SEL_REG -- requirements
Module: mux_sel_reg

---
 rtl/mux_sel_reg.sv | 137 +++++++++++++
 tb/tb_mux_sel_reg.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_reg.sv
// mux_sel_reg: N-channel selector with a single registered output entry.
// Picks one input channel per cycle (explicit sel or round-robin among valid
// channels) and moves its word into an output register with valid/ready
// handshakes on both sides.
//
// Parameters:
//   WIDTH - data bits per channel
//   NCH   - number of input channels (2..16)
//   MODE  - 0: explicit select via sel, 1: round-robin among valid channels
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   in_data  - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid - per-channel valid
//   in_ready - per-channel accept strobe (combinational, one-hot or zero)
//   sel      - channel select (MODE=0 only)
//   y        - registered selected word
//   y_valid  - y holds an unconsumed word
//   y_ready  - downstream accepts y this cycle
//   y_ch     - source channel of the word in y
//   err_sel  - sticky flag: sel was out of range in MODE=0
module mux_sel_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned MODE  = 0,
  localparam int unsigned SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SELW-1:0]      y_ch,
  output logic                 err_sel
);

  logic             space;
  logic             sel_bad;
  logic             grant_ok;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_next;

  // Output entry can take a new word when empty or being drained this cycle.
  assign space   = !y_valid || y_ready;
  assign sel_bad = (MODE == 0) && (32'(sel) >= NCH);

  // Grant selection: explicit sel, or first valid channel at/after rr_ptr
  // with a second pass below rr_ptr to wrap around.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    if (MODE == 0) begin
      grant_ok  = !sel_bad;
      grant_idx = sel;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!grant_ok && in_valid[i] && (i >= 32'(rr_ptr))) begin
          grant_ok  = 1'b1;
          grant_idx = SELW'(i);
        end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!grant_ok && in_valid[i]) begin
          grant_ok  = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end
  end

  // Data/valid mux for the granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_data  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_valid = in_valid[i];
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = grant_ok && grant_valid && space;

  // Accept strobe: only the granted channel, only with room, never in reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      in_ready[i] = !rst && grant_ok && space && (grant_idx == SELW'(i));
    end
  end

  // Round-robin successor, modulo NCH (also for non-power-of-2 NCH).
  assign rr_next = (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + SELW'(1);

  // Output register: load on transfer, clear valid on drain-only cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (xfer) begin
      y       <= grant_data;
      y_ch    <= grant_idx;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the channel just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((MODE == 1) && xfer) begin
      rr_ptr <= rr_next;
    end
  end

  // Sticky out-of-range select flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else if (sel_bad) begin
      err_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_sel_reg.sv
// Testbench for mux_sel_reg. Three instances:
//   dut 0: MODE=0, NCH=4   dut 1: MODE=0, NCH=3   dut 2: MODE=1, NCH=3
// A cycle model predicts in_ready and the output register; transferred words
// go into a per-instance scoreboard queue and are popped when they show up on y.
module tb_mux_sel_reg;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] din [3];
  logic [3:0]  vin [3];
  logic [1:0]  sel [3];
  logic        yr  [3];

  logic [3:0] rdy_a;
  logic [2:0] rdy_b, rdy_c;
  logic [7:0] y_a, y_b, y_c;
  logic       yv_a, yv_b, yv_c;
  logic [1:0] ch_a, ch_b, ch_c;
  logic       err_a, err_b, err_c;

  logic [3:0] rdy_o [3];
  logic [7:0] y_o   [3];
  logic       yv_o  [3];
  logic [1:0] ch_o  [3];
  logic       err_o [3];

  assign rdy_o[0] = rdy_a;
  assign rdy_o[1] = {1'b0, rdy_b};
  assign rdy_o[2] = {1'b0, rdy_c};
  assign y_o[0] = y_a;   assign y_o[1] = y_b;   assign y_o[2] = y_c;
  assign yv_o[0] = yv_a; assign yv_o[1] = yv_b; assign yv_o[2] = yv_c;
  assign ch_o[0] = ch_a; assign ch_o[1] = ch_b; assign ch_o[2] = ch_c;
  assign err_o[0] = err_a; assign err_o[1] = err_b; assign err_o[2] = err_c;

  mux_sel_reg #(.WIDTH(8), .NCH(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy_a),
    .sel(sel[0]), .y(y_a), .y_valid(yv_a), .y_ready(yr[0]), .y_ch(ch_a), .err_sel(err_a));

  mux_sel_reg #(.WIDTH(8), .NCH(3), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .in_data(din[1][23:0]), .in_valid(vin[1][2:0]), .in_ready(rdy_b),
    .sel(sel[1]), .y(y_b), .y_valid(yv_b), .y_ready(yr[1]), .y_ch(ch_b), .err_sel(err_b));

  mux_sel_reg #(.WIDTH(8), .NCH(3), .MODE(1)) u_c (
    .clk(clk), .rst(rst), .in_data(din[2][23:0]), .in_valid(vin[2][2:0]), .in_ready(rdy_c),
    .sel(sel[2]), .y(y_c), .y_valid(yv_c), .y_ready(yr[2]), .y_ch(ch_c), .err_sel(err_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic       m_yv  [3];
  logic [7:0] m_y   [3];
  logic [1:0] m_ch  [3];
  int         m_ptr [3];
  logic       m_err [3];
  exp_t q0[$], q1[$], q2[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int nch_of(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int mode_of(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_yv[k] = 1'b0; m_y[k] = 8'h00; m_ch[k] = 2'd0; m_ptr[k] = 0; m_err[k] = 1'b0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic set_idle();
    for (int k = 0; k < 3; k++) begin
      din[k] = 32'h0; vin[k] = 4'h0; sel[k] = 2'd0; yr[k] = 1'b1;
    end
  endtask

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e, output logic have);
    have = 1'b0;
    e    = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
  endtask

  // One clock cycle for all instances: predict and check in_ready before the
  // edge, advance the model, then check the registered outputs after it.
  // Entered and left just after a falling edge.
  task automatic step();
    logic       xf [3];
    logic [1:0] g  [3];
    exp_t       e;
    logic       have;
    #1;
    for (int k = 0; k < 3; k++) begin
      int n;
      logic ok, sp;
      logic [3:0] er;
      n = nch_of(k);
      ok = 1'b0;
      g[k] = 2'd0;
      sp = !m_yv[k] || yr[k];
      if (mode_of(k) == 0) begin
        ok = (int'(sel[k]) < n);
        g[k] = sel[k];
      end else begin
        for (int off = 0; off < n; off++) begin
          int c;
          c = (m_ptr[k] + off) % n;
          if (!ok && vin[k][c]) begin ok = 1'b1; g[k] = 2'(c); end
        end
      end
      er = (ok && sp) ? (4'b0001 << g[k]) : 4'b0000;
      xf[k] = ok && sp && vin[k][g[k]];
      n_tests++;
      if (rdy_o[k] !== er) begin
        n_fail++;
        $display("FAIL in_ready dut%0d t=%0t: got %b want %b", k, $time, rdy_o[k], er);
      end
      n_tests++;
      if (!$onehot0(rdy_o[k])) begin
        n_fail++;
        $display("FAIL in_ready_onehot0 dut%0d t=%0t: got %b want one-hot-or-zero", k, $time, rdy_o[k]);
      end
      if ((mode_of(k) == 0) && (int'(sel[k]) >= n)) m_err[k] = 1'b1;
      if (xf[k]) begin
        e.data = din[k][int'(g[k])*8 +: 8];
        e.ch   = g[k];
        sb_push(k, e);
        m_yv[k]  = 1'b1;
        m_y[k]   = e.data;
        m_ch[k]  = g[k];
        m_ptr[k] = (int'(g[k]) + 1) % n;
      end else if (yr[k]) begin
        m_yv[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (xf[k]) begin
        sb_pop(k, e, have);
        n_tests++;
        if (!have || (y_o[k] !== e.data) || (ch_o[k] !== e.ch)) begin
          n_fail++;
          $display("FAIL scoreboard dut%0d t=%0t: got y=%h ch=%0d want y=%h ch=%0d (entry=%0b)",
                   k, $time, y_o[k], ch_o[k], e.data, e.ch, have);
        end
      end
      n_tests++;
      if ((yv_o[k] !== m_yv[k]) || (y_o[k] !== m_y[k]) || (ch_o[k] !== m_ch[k]) ||
          (err_o[k] !== m_err[k])) begin
        n_fail++;
        $display("FAIL outputs dut%0d t=%0t: got yv=%b y=%h ch=%0d err=%b want yv=%b y=%h ch=%0d err=%b",
                 k, $time, yv_o[k], y_o[k], ch_o[k], err_o[k], m_yv[k], m_y[k], m_ch[k], m_err[k]);
      end
    end
    @(negedge clk);
  endtask

  // Hold reset across one clock with active inputs; everything must read zero.
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = 32'hDEADBEEF; vin[k] = 4'hF; sel[k] = 2'd1; yr[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ((y_o[k] !== 8'h00) || (yv_o[k] !== 1'b0) || (ch_o[k] !== 2'd0) ||
          (err_o[k] !== 1'b0) || (rdy_o[k] !== 4'h0)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got y=%h yv=%b ch=%0d err=%b rdy=%b want all 0",
                 k, y_o[k], yv_o[k], ch_o[k], err_o[k], rdy_o[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_idle();
  endtask

  // Explicit select of channel 2, then a drain-only cycle.
  task automatic test_basic();
    sel[0] = 2'd2;
    vin[0] = 4'b0100;
    din[0] = {8'h44, 8'hA5, 8'h22, 8'h11};
    yr[0]  = 1'b1;
    #1;
    n_tests++;
    if (rdy_a !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_in_ready: got %b want 0100", rdy_a);
    end
    step();
    n_tests++;
    if ((y_a !== 8'hA5) || (ch_a !== 2'd2) || (yv_a !== 1'b1)) begin
      n_fail++;
      $display("FAIL basic_out: got y=%h ch=%0d yv=%b want y=a5 ch=2 yv=1", y_a, ch_a, yv_a);
    end
    vin[0] = 4'b0000;
    step();
    n_tests++;
    if ((yv_a !== 1'b0) || (y_a !== 8'hA5) || (ch_a !== 2'd2)) begin
      n_fail++;
      $display("FAIL drain_only: got y=%h ch=%0d yv=%b want y=a5 ch=2 yv=0", y_a, ch_a, yv_a);
    end
  endtask

  // Stall for three cycles while inputs churn, then replace with no bubble.
  task automatic test_stall();
    sel[0] = 2'd1;
    vin[0] = 4'hF;
    din[0] = {8'h00, 8'h00, 8'h11, 8'h00};
    yr[0]  = 1'b1;
    step();
    yr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[0] = $urandom();
      sel[0] = 2'(i);
      step();
      n_tests++;
      if ((y_a !== 8'h11) || (yv_a !== 1'b1) || (ch_a !== 2'd1)) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got y=%h yv=%b ch=%0d want y=11 yv=1 ch=1", i, y_a, yv_a, ch_a);
      end
    end
    yr[0]  = 1'b1;
    sel[0] = 2'd3;
    din[0] = {8'h5C, 8'h00, 8'h00, 8'h00};
    step();
    n_tests++;
    if ((y_a !== 8'h5C) || (yv_a !== 1'b1) || (ch_a !== 2'd3)) begin
      n_fail++;
      $display("FAIL stall_release: got y=%h yv=%b ch=%0d want y=5c yv=1 ch=3", y_a, yv_a, ch_a);
    end
    set_idle();
    step();
  endtask

  // One word per cycle with y_ready held high.
  task automatic test_back_to_back();
    vin[0] = 4'hF;
    yr[0]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din[0] = $urandom();
      sel[0] = 2'(i % 4);
      step();
      n_tests++;
      if (yv_a !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back%0d: got yv=%b want 1", i, yv_a);
      end
    end
    set_idle();
    step();
  endtask

  // Round-robin over NCH=3 with pointer wrap 2 -> 0.
  task automatic test_round_robin();
    int seq1 [6] = '{0, 1, 2, 0, 1, 2};
    int seq2 [4] = '{0, 2, 0, 2};
    vin[2] = 4'b0111;
    yr[2]  = 1'b1;
    din[2] = 32'h00_C2_B1_A0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (int'(ch_c) != seq1[i]) begin
        n_fail++;
        $display("FAIL rr_all%0d: got ch=%0d want %0d", i, ch_c, seq1[i]);
      end
    end
    vin[2] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (int'(ch_c) != seq2[i]) begin
        n_fail++;
        $display("FAIL rr_101_%0d: got ch=%0d want %0d", i, ch_c, seq2[i]);
      end
    end
    set_idle();
    step();
  endtask

  // Out-of-range sel on NCH=3: no grant, sticky error.
  task automatic test_err_sel();
    sel[1] = 2'd3;
    vin[1] = 4'b0111;
    yr[1]  = 1'b1;
    vin[2] = 4'b0111;
    sel[2] = 2'd3;
    step();
    n_tests++;
    if ((err_b !== 1'b1) || (yv_b !== 1'b0)) begin
      n_fail++;
      $display("FAIL err_set: got err=%b yv=%b want err=1 yv=0", err_b, yv_b);
    end
    sel[1] = 2'd0;
    step();
    step();
    n_tests++;
    if (err_b !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b want 1", err_b);
    end
    n_tests++;
    if (err_c !== 1'b0) begin
      n_fail++;
      $display("FAIL err_mode1: got err=%b want 0", err_c);
    end
    set_idle();
    step();
  endtask

  // Mid-cycle reset while words are held; arbitration restarts at channel 0.
  task automatic test_async_reset();
    din[0] = 32'h0000_7700;
    sel[0] = 2'd1;
    vin[0] = 4'b0010;
    vin[2] = 4'b0111;
    din[2] = 32'h0033_2211;
    step();
    for (int k = 0; k < 3; k++) begin
      vin[k] = 4'h0;
      yr[k]  = 1'b0;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ((y_o[k] !== 8'h00) || (yv_o[k] !== 1'b0) || (ch_o[k] !== 2'd0) ||
          (err_o[k] !== 1'b0) || (rdy_o[k] !== 4'h0)) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got y=%h yv=%b ch=%0d err=%b rdy=%b want all 0",
                 k, y_o[k], yv_o[k], ch_o[k], err_o[k], rdy_o[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_idle();
    vin[2] = 4'b0111;
    din[2] = 32'h0033_2211;
    step();
    n_tests++;
    if ((ch_c !== 2'd0) || (yv_c !== 1'b1) || (y_c !== 8'h11)) begin
      n_fail++;
      $display("FAIL rr_restart: got ch=%0d yv=%b y=%h want ch=0 yv=1 y=11", ch_c, yv_c, y_c);
    end
    set_idle();
    step();
  endtask

  // Random traffic on all instances; the cycle model checks every cycle.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        din[k] = $urandom();
        vin[k] = 4'($urandom_range(0, 15));
        sel[k] = 2'($urandom_range(0, 3));
        yr[k]  = ($urandom_range(0, 9) < 7);
      end
      step();
    end
    set_idle();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    do_reset();
    test_round_robin();
    test_err_sel();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at t=%0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
